keynsham_prefetch: RTL and testbench



---
 rtl/keynsham_prefetch.sv | 194 +++++++++++++++++++
 tb/tb_keynsham_prefetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keynsham_prefetch.sv
// keynsham_prefetch: instruction prefetch queue in front of the on-chip RAM
// instruction port. Issues one word fetch at a time, buffers returned words
// with their PC, and hands them to decode over valid/ready. Redirects flush
// the queue and drop any stale in-flight response. A missing acknowledge
// becomes a fault entry after TIMEOUT wait cycles.
//
// Optional feature: define KEYNSHAM_PREFETCH_BYPASS_EN to forward a response
// straight to out_* in its ack cycle when the queue is empty.
module keynsham_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        i_access,
    output logic [29:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [29:0] out_pc,
    output logic        out_fault
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Control state
    logic [1:0]       r_state;
    logic [29:0]      r_fetch_pc;
    logic             r_discard;
    logic [7:0]       r_timer;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    // Queue storage (data only, no reset needed)
    logic [29:0] r_mem_pc    [DEPTH];
    logic [31:0] r_mem_instr [DEPTH];
    logic        r_mem_fault [DEPTH];

    logic        w_in_wait;
    logic        w_ack_live;
    logic        w_fault_push;
    logic        w_empty;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_instr;

    assign w_in_wait    = (r_state == S_WAIT);
    // A response that is really ours: not stale and not overtaken by a redirect.
    assign w_ack_live   = w_in_wait && i_ack && !r_discard && !redirect;
    assign w_fault_push = w_in_wait && !i_ack && (r_timer == TIMEOUT_C)
                          && !r_discard && !redirect;
    assign w_empty      = (r_count == '0);

`ifdef KEYNSHAM_PREFETCH_BYPASS_EN
    assign w_bypass = w_ack_live && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed in its ack cycle never occupies a slot.
    assign w_push       = (w_ack_live && !(w_bypass && out_ready)) || w_fault_push;
    // A pop during a redirect is not a transfer; the flush wins.
    assign w_pop        = !w_empty && out_ready && !redirect;
    assign w_push_instr = w_fault_push ? 32'h0 : i_data;

    // Only one request may be outstanding, and only when a slot is free for it.
    assign i_access = rst_n && (r_state == S_ISSUE) && (r_count < DEPTH_C) && !redirect;
    assign i_addr   = r_fetch_pc;

    // Present queue head (or the bypassed response); zeros when nothing is valid.
    always_comb begin
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_pc    = 30'h0;
        out_fault = 1'b0;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_instr = r_mem_instr[r_rptr];
            out_pc    = r_mem_pc[r_rptr];
            out_fault = r_mem_fault[r_rptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_instr = i_data;
            out_pc    = r_fetch_pc;
        end
    end

    // Fetch FSM: issue, wait for ack or timeout, halt on fault; redirect overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ISSUE;
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
            r_timer    <= 8'h0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            if (w_in_wait && !i_ack) begin
                // Old request still in flight: wait for it, then throw it away.
                // Timer restarts so the stale response always lands before expiry.
                r_state   <= S_WAIT;
                r_discard <= 1'b1;
                r_timer   <= 8'h0;
            end else begin
                r_state   <= S_ISSUE;
                r_discard <= 1'b0;
            end
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (i_access) begin
                        r_state <= S_WAIT;
                        r_timer <= 8'h0;
                    end
                end
                S_WAIT: begin
                    if (i_ack) begin
                        if (!r_discard) begin
                            r_fetch_pc <= r_fetch_pc + 30'd1;
                        end
                        r_discard <= 1'b0;
                        r_state   <= S_ISSUE;
                    end else if (r_timer == TIMEOUT_C) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_state <= S_HALT;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_ISSUE;
                end
            endcase
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (redirect) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage write; space is guaranteed because issue requires a free slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]    <= r_fetch_pc;
            r_mem_instr[r_wptr] <= w_push_instr;
            r_mem_fault[r_wptr] <= w_fault_push;
        end
    end

endmodule

// File: tb/tb_keynsham_prefetch.sv
// Directed bench for keynsham_prefetch with a small RAM responder whose ack
// latency is adjustable and which never answers a fetch of word 0x3FF.
module tb_keynsham_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h100;
    localparam int unsigned TIMEOUT  = 4;
`ifdef KEYNSHAM_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        i_access;
    logic [29:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [29:0] out_pc;
    logic        out_fault;

    int total;
    int bad;

    keynsham_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .i_access    (i_access),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_ack       (i_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_fault   (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder: ack ram_lat cycles after the request, data = {2'b10, addr}.
    logic [1:0]  ram_cnt;
    logic [29:0] ram_addr;
    logic [1:0]  ram_lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cnt  <= 2'd0;
            ram_addr <= 30'h0;
        end else if (i_access && i_addr != 30'h3FF) begin
            ram_cnt  <= ram_lat;
            ram_addr <= i_addr;
        end else if (ram_cnt != 2'd0) begin
            ram_cnt <= ram_cnt - 2'd1;
        end
    end
    assign i_ack  = (ram_cnt == 2'd1);
    assign i_data = {2'b10, ram_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_access(input string tag);
        int c;
        c = 0;
        while (!i_access && c < 20) begin
            nxt();
            c++;
        end
        chk(tag, 32'(i_access), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        int t_iss;
        int t_flt;
        int c;
        logic [29:0] exp_pc;

        total       = 0;
        bad         = 0;
        redirect    = 1'b0;
        redirect_pc = 30'h0;
        out_ready   = 1'b1;
        ram_lat     = 2'd1;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset state
        nxt();
        chk("rst_access", 32'(i_access), 32'd0);
        chk("rst_addr",   32'(i_addr),   32'h100);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_instr",  out_instr,      32'h0);
        chk("rst_pc",     32'(out_pc),    32'h0);
        chk("rst_fault",  32'(out_fault), 32'd0);

        // Release: stream from 0x100 with 1-cycle RAM
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("w0_access", 32'(i_access), 32'd1);
        chk("w0_addr",   32'(i_addr),   32'h100);
        nxt();
        chk("w1_access", 32'(i_access), 32'd0);
        chk("w1_valid",  32'(out_valid), 32'd0);
        nxt();
        chk("w2_valid",  32'(out_valid), 32'd1);
        chk("w2_pc",     32'(out_pc),    32'h100);
        chk("w2_instr",  out_instr,      32'h8000_0100);
        chk("w2_access", 32'(i_access),  32'd1);
        chk("w2_addr",   32'(i_addr),    32'h101);
        nxt();
        chk("w3_valid",  32'(out_valid), 32'd0);
        nxt();
        chk("w4_pc",     32'(out_pc),    32'h101);
        nxt();
        nxt();
        chk("w6_pc",     32'(out_pc),    32'h102);
        chk("w6_access", 32'(i_access),  32'd1);

        // Backpressure: queue fills, fetching stops
        out_ready = 1'b0;
        #1;
        n = 0;
        repeat (12) begin
            if (i_access) n++;
            nxt();
        end
        chk("bp_fetches", 32'(n),         32'd3);
        chk("bp_stalled", 32'(i_access),  32'd0);
        chk("bp_head",    32'(out_pc),    32'h102);
        chk("bp_valid",   32'(out_valid), 32'd1);

        // Resume: words come out in order, none lost or duplicated
        out_ready = 1'b1;
        #1;
        exp_pc = 30'h102;
        got = 0;
        c = 0;
        while (c < 40 && got < 6) begin
            if (out_valid) begin
                chk("drain_pc",    32'(out_pc), 32'(exp_pc));
                chk("drain_instr", out_instr,   {2'b10, exp_pc});
                exp_pc = exp_pc + 30'd1;
                got++;
            end
            nxt();
            c++;
        end
        chk("drain_cnt", 32'(got), 32'd6);

        // Redirect while a slow request is in flight: stale response dropped
        ram_lat = 2'd3;
        wait_access("inflight_issue");
        nxt();
        redirect    = 1'b1;
        redirect_pc = 30'h2000;
        #1;
        chk("inflight_noacc", 32'(i_access), 32'd0);
        nxt();
        redirect = 1'b0;
        ram_lat  = 2'd1;
        #1;
        chk("inflight_flushed", 32'(out_valid), 32'd0);
        chk("inflight_wait",    32'(i_access),  32'd0);
        c = 0;
        while (!out_valid && c < 20) begin
            nxt();
            c++;
        end
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc",    32'(out_pc),    32'h2000);
        chk("redir_instr", out_instr,      32'h8000_2000);

        // Redirect coincident with an ack and a pop
        out_ready = 1'b0;
        wait_access("coin_first");
        nxt();
        wait_access("coin_second");
        nxt();
        redirect    = 1'b1;
        redirect_pc = 30'h3FC;
        out_ready   = 1'b1;
        #1;
        chk("coin_ack",    32'(i_ack),     32'd1);
        chk("coin_valid",  32'(out_valid), 32'd1);
        chk("coin_noacc",  32'(i_access),  32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("coin_empty",  32'(out_valid), 32'd0);
        chk("coin_access", 32'(i_access),  32'd1);
        chk("coin_addr",   32'(i_addr),    32'h3FC);

        // Stream into the dead word 0x3FF: timeout fault entry, then halt
        exp_pc = 30'h3FC;
        got = 0;
        t_iss = -1;
        t_flt = -1;
        c = 0;
        while (c < 40 && got < 4) begin
            if (i_access && i_addr == 30'h3FF) t_iss = c;
            if (out_valid) begin
                chk("to_pc", 32'(out_pc), 32'(exp_pc));
                if (exp_pc == 30'h3FF) begin
                    chk("to_fault_instr", out_instr,      32'h0);
                    chk("to_fault_flag",  32'(out_fault), 32'd1);
                    t_flt = c;
                end else begin
                    chk("to_instr", out_instr,      {2'b10, exp_pc});
                    chk("to_flag",  32'(out_fault), 32'd0);
                end
                exp_pc = exp_pc + 30'd1;
                got++;
            end
            nxt();
            c++;
        end
        chk("to_cnt",     32'(got),           32'd4);
        chk("to_latency", 32'(t_flt - t_iss), 32'(TIMEOUT + 2));
        n = 0;
        repeat (20) begin
            if (i_access) n++;
            nxt();
        end
        chk("halt_noacc", 32'(n),         32'd0);
        chk("halt_empty", 32'(out_valid), 32'd0);

        // Leave halt by redirect to the top word; address wraps to 0
        redirect    = 1'b1;
        redirect_pc = 30'h3FFF_FFFF;
        #1;
        chk("wrap_suppr", 32'(i_access), 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("wrap_access", 32'(i_access), 32'd1);
        chk("wrap_addr",   32'(i_addr),   32'h3FFF_FFFF);
        nxt();
        chk("wrap_ack",       32'(i_ack),     32'd1);
        chk("wrap_ack_valid", 32'(out_valid), 32'(BYP));
        chk("wrap_ack_pc",    32'(out_pc),    BYP ? 32'h3FFF_FFFF : 32'h0);
        nxt();
        chk("wrap_q_valid", 32'(out_valid), BYP ? 32'd0 : 32'd1);
        chk("wrap_q_instr", out_instr,      BYP ? 32'h0 : 32'hBFFF_FFFF);
        chk("wrap_next_acc",  32'(i_access), 32'd1);
        chk("wrap_next_addr", 32'(i_addr),   32'h0);
        nxt();
        nxt();
        chk("wrap0_valid", 32'(out_valid), BYP ? 32'd0 : 32'd1);
        chk("wrap0_instr", out_instr,      BYP ? 32'h0 : 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
